hidden_layer_mac: RTL and testbench

Sequential hidden layer of the Milestone 1 DNN. It sits directly downstream of the input layer and consumes its four registered signed activations and `input_ready` strobe. It computes four neurons' weighted sums with one multiply-accumulate per neuron per cycle, adds the bias, applies ReLU, scales and saturates, and presents four activations with a one-cycle `output_ready` strobe. Weights and biases are written at run time through a simple register write port.

---
 rtl/dnn_pkg.sv | 66 ++++++
 rtl/hidden_layer_mac_if.sv | 47 ++++
 rtl/mac_neuron.sv | 59 +++++
 rtl/hidden_layer_mac.sv | 140 ++++++++++++++
 tb/tb_hidden_layer_mac.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/dnn_pkg.sv
// -----------------------------------------------------------------------------
// dnn_pkg
// Shared definitions for the DNN layers: default widths, layer dimensions,
// the hidden-layer FSM state type and the shift/ReLU/saturate helper used to
// turn a wide accumulator into an output activation.
//
// Build option:
//   HIDDEN_RELU_EN  defined   -> ReLU applied, outputs in [0, 2^(OW-1)-1]
//                   undefined -> signed saturation to [-2^(OW-1), 2^(OW-1)-1]
// -----------------------------------------------------------------------------
package dnn_pkg;

    localparam int INPUT_WIDTH  = 5;
    localparam int WEIGHT_WIDTH = 5;
    localparam int ACC_WIDTH    = 12;
    localparam int OUTPUT_WIDTH = 5;
    localparam int FRAC_SHIFT   = 2;

    localparam int NUM_NEURONS  = 4;
    localparam int NUM_INPUTS   = 4;
    localparam int NUM_WEIGHTS  = NUM_NEURONS * NUM_INPUTS;

    localparam int W_ADDR_WIDTH = $clog2(NUM_WEIGHTS);
    localparam int B_ADDR_WIDTH = $clog2(NUM_NEURONS);
    localparam int IDX_WIDTH    = $clog2(NUM_INPUTS);

`ifdef HIDDEN_RELU_EN
    localparam bit RELU_EN = 1'b1;
`else
    localparam bit RELU_EN = 1'b0;
`endif

    typedef logic signed [INPUT_WIDTH-1:0]              act_in_t;
    typedef logic signed [WEIGHT_WIDTH-1:0]             weight_t;
    typedef logic signed [ACC_WIDTH-1:0]                acc_t;
    typedef logic signed [OUTPUT_WIDTH-1:0]             act_out_t;
    typedef logic signed [INPUT_WIDTH+WEIGHT_WIDTH-1:0] prod_t;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } hl_state_t;

    // Output range expressed at accumulator width so comparisons stay signed.
    localparam acc_t ACC_SAT_MAX = acc_t'((1 <<< (OUTPUT_WIDTH - 1)) - 1);
    localparam acc_t ACC_SAT_MIN = acc_t'(-(1 <<< (OUTPUT_WIDTH - 1)));

    // Arithmetic shift (rounds toward -inf), optional ReLU, then clamp.
    function automatic act_out_t shift_saturate(input acc_t acc);
        acc_t     shifted;
        act_out_t result;
        shifted = acc >>> FRAC_SHIFT;
        if (RELU_EN && shifted[ACC_WIDTH-1]) begin
            result = '0;
        end else if (shifted > ACC_SAT_MAX) begin
            result = ACC_SAT_MAX[OUTPUT_WIDTH-1:0];
        end else if (shifted < ACC_SAT_MIN) begin
            result = ACC_SAT_MIN[OUTPUT_WIDTH-1:0];
        end else begin
            result = shifted[OUTPUT_WIDTH-1:0];
        end
        return result;
    endfunction

endpackage : dnn_pkg

// File: rtl/hidden_layer_mac_if.sv
// -----------------------------------------------------------------------------
// hidden_layer_mac_if
// Bundles the hidden layer's data-path and configuration signals.
//   input_ready, in0..in3       : activation strobe and values from input layer
//   w_we, w_addr, w_data        : weight write port (addr = neuron*4 + input)
//   b_we, b_addr, b_data        : bias write port (addr = neuron)
//   out0..out3, output_ready    : result activations and one-cycle strobe
//   busy, overrun               : status (FSM not idle / dropped strobe seen)
// Modports: master = upstream driver, slave = hidden layer.
// -----------------------------------------------------------------------------
interface hidden_layer_mac_if;
    import dnn_pkg::*;

    logic                    input_ready;
    act_in_t                 in0;
    act_in_t                 in1;
    act_in_t                 in2;
    act_in_t                 in3;

    logic                    w_we;
    logic [W_ADDR_WIDTH-1:0] w_addr;
    weight_t                 w_data;
    logic                    b_we;
    logic [B_ADDR_WIDTH-1:0] b_addr;
    weight_t                 b_data;

    act_out_t                out0;
    act_out_t                out1;
    act_out_t                out2;
    act_out_t                out3;
    logic                    output_ready;
    logic                    busy;
    logic                    overrun;

    modport master (
        output input_ready, in0, in1, in2, in3,
        output w_we, w_addr, w_data, b_we, b_addr, b_data,
        input  out0, out1, out2, out3, output_ready, busy, overrun
    );

    modport slave (
        input  input_ready, in0, in1, in2, in3,
        input  w_we, w_addr, w_data, b_we, b_addr, b_data,
        output out0, out1, out2, out3, output_ready, busy, overrun
    );

endinterface : hidden_layer_mac_if

// File: rtl/mac_neuron.sv
// -----------------------------------------------------------------------------
// mac_neuron
// One hidden neuron: accumulator with bias preload, one signed MAC per cycle,
// and a registered shift/ReLU/saturate output that reads zero when not emitting.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : preload accumulator with sign-extended bias
//   bias      : bias value used by load
//   step      : accumulate x * w
//   x, w      : current activation and weight
//   emit      : register the converted accumulator this cycle (else output 0)
//   act       : registered output activation
// -----------------------------------------------------------------------------
module mac_neuron
    import dnn_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  weight_t  bias,
    input  logic     step,
    input  act_in_t  x,
    input  weight_t  w,
    input  logic     emit,
    output act_out_t act
);

    acc_t     acc_q, acc_d;
    act_out_t act_q, act_d;
    prod_t    prod;

    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        prod  = prod_t'(x) * prod_t'(w);
        acc_d = acc_q;
        if (load) begin
            acc_d = acc_t'(bias);
        end else if (step) begin
            acc_d = acc_q + acc_t'(prod);
        end
        act_d = emit ? shift_saturate(acc_q) : '0;
    end

    // NOTE: state updates use non-blocking assignment so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            act_q <= '0;
        end else begin
            acc_q <= acc_d;
            act_q <= act_d;
        end
    end

    assign act = act_q;

endmodule : mac_neuron

// File: rtl/hidden_layer_mac.sv
// -----------------------------------------------------------------------------
// hidden_layer_mac
// Sequential four-neuron hidden layer. Accepts four activations on
// input_ready, runs four MAC cycles (one input per cycle, all neurons in
// parallel), then presents shifted/saturated activations with a one-cycle
// output_ready strobe. Weights/biases are written at run time while idle.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   hl   : hidden_layer_mac_if.slave (data, write ports, status)
// Build option: HIDDEN_RELU_EN (see dnn_pkg) selects ReLU vs signed saturation.
// -----------------------------------------------------------------------------
module hidden_layer_mac
    import dnn_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    hidden_layer_mac_if.slave  hl
);

    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_INPUTS - 1);

    hl_state_t             state_q, state_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    act_in_t               x_q [NUM_INPUTS];
    act_in_t               x_d [NUM_INPUTS];
    weight_t               weight_q [NUM_WEIGHTS];
    weight_t               weight_d [NUM_WEIGHTS];
    weight_t               bias_q [NUM_NEURONS];
    weight_t               bias_d [NUM_NEURONS];
    logic                  overrun_q, overrun_d;
    logic                  output_ready_q, output_ready_d;

    logic                  load;
    logic                  step;
    logic                  emit;
    weight_t               w_sel [NUM_NEURONS];
    act_out_t              act [NUM_NEURONS];

    // FSM next state and per-cycle controls.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        step    = 1'b0;
        emit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hl.input_ready) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                step  = 1'b1;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                emit    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Input latch, parameter writes and status.
    always_comb begin
        x_d = x_q;
        if (load) begin
            x_d[0] = hl.in0;
            x_d[1] = hl.in1;
            x_d[2] = hl.in2;
            x_d[3] = hl.in3;
        end

        weight_d = weight_q;
        bias_d   = bias_q;
        if (state_q == IDLE) begin
            if (hl.w_we) weight_d[hl.w_addr] = hl.w_data;
            if (hl.b_we) bias_d[hl.b_addr]   = hl.b_data;
        end

        overrun_d      = overrun_q | (hl.input_ready && (state_q != IDLE));
        output_ready_d = (state_q == OUT);

        for (int n = 0; n < NUM_NEURONS; n++) begin
            w_sel[n] = weight_q[n * NUM_INPUTS + int'(idx_q)];
        end
    end

    // NOTE: the weight/bias register files are ordinary flops cleared by
    // reset, since a freshly reset layer must compute with all-zero parameters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            x_q            <= '{default: '0};
            weight_q       <= '{default: '0};
            bias_q         <= '{default: '0};
            overrun_q      <= 1'b0;
            output_ready_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            x_q            <= x_d;
            weight_q       <= weight_d;
            bias_q         <= bias_d;
            overrun_q      <= overrun_d;
            output_ready_q <= output_ready_d;
        end
    end

    // Preload uses bias_d so a bias write in the accepting cycle takes effect.
    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
        mac_neuron u_neuron (
            .clk  (clk),
            .rst  (rst),
            .load (load),
            .bias (bias_d[n]),
            .step (step),
            .x    (x_q[idx_q]),
            .w    (w_sel[n]),
            .emit (emit),
            .act  (act[n])
        );
    end

    assign hl.out0         = act[0];
    assign hl.out1         = act[1];
    assign hl.out2         = act[2];
    assign hl.out3         = act[3];
    assign hl.output_ready = output_ready_q;
    assign hl.busy         = (state_q != IDLE);
    assign hl.overrun      = overrun_q;

endmodule : hidden_layer_mac

// File: tb/tb_hidden_layer_mac.sv
// -----------------------------------------------------------------------------
// tb_hidden_layer_mac
// Directed vectors with hand-computed expectations for hidden_layer_mac.
// Expected values that depend on HIDDEN_RELU_EN are selected at compile time.
// -----------------------------------------------------------------------------
module tb_hidden_layer_mac;
    import dnn_pkg::*;

`ifdef HIDDEN_RELU_EN
    localparam int NEG_SMALL = 0;     // -10 >>> 2 clipped by ReLU
    localparam int NEG_SAT   = 0;     // -916 >>> 2 clipped by ReLU
`else
    localparam int NEG_SMALL = -3;    // -10 >>> 2
    localparam int NEG_SAT   = -16;   // -229 saturates low
`endif

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    hidden_layer_mac_if hl ();

    hidden_layer_mac dut (
        .clk (clk),
        .rst (rst),
        .hl  (hl)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_weight(input int n, input int i, input int v);
        hl.w_we   = 1'b1;
        hl.w_addr = 4'(n * 4 + i);
        hl.w_data = 5'(v);
        tick();
        hl.w_we   = 1'b0;
    endtask

    task automatic set_all_weights(input int v);
        for (int k = 0; k < NUM_WEIGHTS; k++) set_weight(k / 4, k % 4, v);
    endtask

    task automatic set_bias(input int n, input int v);
        hl.b_we   = 1'b1;
        hl.b_addr = 2'(n);
        hl.b_data = 5'(v);
        tick();
        hl.b_we   = 1'b0;
    endtask

    task automatic set_all_bias(input int v);
        for (int n = 0; n < NUM_NEURONS; n++) set_bias(n, v);
    endtask

    task automatic drive_inputs(input int a, input int b, input int c, input int d);
        hl.in0 = 5'(a);
        hl.in1 = 5'(b);
        hl.in2 = 5'(c);
        hl.in3 = 5'(d);
    endtask

    task automatic check_outs(input string tag, input int e0, input int e1,
                              input int e2, input int e3);
        check({tag, "_out0"}, hl.out0, e0);
        check({tag, "_out1"}, hl.out1, e1);
        check({tag, "_out2"}, hl.out2, e2);
        check({tag, "_out3"}, hl.out3, e3);
    endtask

    // Waits (bounded) for output_ready and checks how many cycles it took.
    task automatic wait_result(input string tag, input int exp_cycles);
        int cnt = 0;
        do begin
            tick();
            cnt++;
        end while (hl.output_ready !== 1'b1 && cnt < 10);
        check({tag, "_latency"}, cnt, exp_cycles);
        check({tag, "_ready"}, hl.output_ready, 1);
    endtask

    // After a result: strobe drops, outputs return to 0, layer is idle.
    task automatic check_after(input string tag);
        tick();
        check({tag, "_ready_drop"}, hl.output_ready, 0);
        check({tag, "_out_zero"}, hl.out0, 0);
        check({tag, "_idle"}, hl.busy, 0);
    endtask

    task automatic run_sample(input string tag, input int a, input int b,
                              input int c, input int d, input int e0,
                              input int e1, input int e2, input int e3);
        drive_inputs(a, b, c, d);
        hl.input_ready = 1'b1;
        tick();                                  // E0
        hl.input_ready = 1'b0;
        check({tag, "_busy"}, hl.busy, 1);
        wait_result(tag, 5);                     // E5
        check_outs(tag, e0, e1, e2, e3);
        check_after(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        hl.input_ready = 1'b0;
        hl.w_we = 1'b0;  hl.w_addr = '0;  hl.w_data = '0;
        hl.b_we = 1'b0;  hl.b_addr = '0;  hl.b_data = '0;
        drive_inputs(0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check_outs("rst", 0, 0, 0, 0);
        check("rst_ready", hl.output_ready, 0);
        check("rst_busy", hl.busy, 0);
        check("rst_overrun", hl.overrun, 0);

        // Weights 1, bias 0, inputs 1..4: sum 10 >>> 2 = 2.
        set_all_weights(1);
        set_all_bias(0);
        run_sample("ones", 1, 2, 3, 4, 2, 2, 2, 2);

        // 4*15*15 + 15 = 915 >>> 2 = 228 -> saturates to 15.
        set_all_weights(15);
        set_all_bias(15);
        run_sample("sat_hi", 15, 15, 15, 15, 15, 15, 15, 15);

        // 15 * -15 * 4 - 16 = -916 >>> 2 = -229 -> low saturation or ReLU.
        set_all_bias(-16);
        run_sample("sat_lo", -15, -15, -15, -15, NEG_SAT, NEG_SAT, NEG_SAT, NEG_SAT);

        // Weights -1, inputs 1..4: -10 >>> 2 = -3 or ReLU 0.
        set_all_weights(-1);
        set_all_bias(0);
        run_sample("neg", 1, 2, 3, 4, NEG_SMALL, NEG_SMALL, NEG_SMALL, NEG_SMALL);

        // Neuron n sees only input n, bias 4n; exercises address mapping.
        // acc = {8, -4+4, 12+8, 4+12} -> {2, 0, 5, 4}.
        set_all_weights(0);
        for (int n = 0; n < NUM_NEURONS; n++) begin
            set_weight(n, n, 1);
            set_bias(n, 4 * n);
        end
        run_sample("ident", 8, -4, 12, 4, 2, 0, 5, 4);

        // Second input_ready at E2 is dropped and sets overrun.
        set_all_weights(1);
        set_all_bias(0);
        drive_inputs(1, 2, 3, 4);
        hl.input_ready = 1'b1;
        tick();                                  // E0
        hl.input_ready = 1'b0;
        tick();                                  // E1
        drive_inputs(5, 5, 5, 5);
        hl.input_ready = 1'b1;
        tick();                                  // E2
        hl.input_ready = 1'b0;
        check("ovr_flag", hl.overrun, 1);
        wait_result("ovr", 3);                   // E5
        check_outs("ovr", 2, 2, 2, 2);
        check_after("ovr");
        for (int k = 0; k < 6; k++) begin
            tick();
            check("ovr_no_second", hl.output_ready, 0);
        end
        check("ovr_sticky", hl.overrun, 1);

        // Weight write during MAC is ignored (would make neuron0 = 10).
        drive_inputs(1, 2, 3, 4);
        hl.input_ready = 1'b1;
        tick();                                  // E0
        hl.input_ready = 1'b0;
        tick();                                  // E1
        hl.w_we = 1'b1;  hl.w_addr = 4'd3;  hl.w_data = 5'sd9;
        tick();                                  // E2
        hl.w_we = 1'b0;
        wait_result("wmac", 3);
        check_outs("wmac", 2, 2, 2, 2);
        check_after("wmac");

        // Same weight written in IDLE, plus a bias write in the accepting
        // cycle: n0 = 1+2+3+36 = 42 -> 10, n1 = 10 + 8 = 18 -> 4.
        set_weight(0, 3, 9);
        hl.b_we = 1'b1;  hl.b_addr = 2'd1;  hl.b_data = 5'sd8;
        run_sample("widle", 1, 2, 3, 4, 10, 4, 2, 2);
        hl.b_we = 1'b0;

        // Reset at E3 aborts the sample and clears everything.
        drive_inputs(1, 2, 3, 4);
        hl.input_ready = 1'b1;
        tick();                                  // E0
        hl.input_ready = 1'b0;
        tick();                                  // E1
        tick();                                  // E2
        rst = 1'b1;
        tick();                                  // E3
        rst = 1'b0;
        check("rst3_busy", hl.busy, 0);
        check("rst3_ready", hl.output_ready, 0);
        check("rst3_overrun", hl.overrun, 0);
        check_outs("rst3", 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rst3_no_ready", hl.output_ready, 0);
        end
        // Parameters were cleared: any input gives 0.
        run_sample("rst3_zero", 7, -5, 3, 15, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_hidden_layer_mac
